ingress_port_sched: RTL and testbench
=====================================

# ingress_port_sched

Two-port commit scheduler sitting between the CVA6 commit stage and `ingress_fsm`. CVA6 retires up to two instructions per cycle, but `ingress_fsm` consumes exactly one `mure_pkg::fifo_entry_s` per cycle. This block buffers both commit ports in program order in a small circular FIFO and streams one entry per cycle into the FSM. It raises backpressure when space runs out and records any drops.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥4.

Ports:
- `clk_i` input, 1: clock; all state on rising edge.
- `rst_i` input, 1: reset; asynchronous, active-high.
- `port0_entry_i` input, `fifo_entry_s`: commit port 0 (older); pushes when `.valid`.
- `port1_entry_i` input, `fifo_entry_s`: commit port 1 (younger); pushes when `.valid`.
- `flush_i` input, 1: synchronous flush of FIFO and output register.
- `ready_o` output, 1: ≥2 free slots; the combinational decode of `count`.
- `fifo_entry_o` output, `fifo_entry_s`: registered entry to `ingress_fsm`; `.valid` is the output-valid qualifier.
- `overflow_o` output, 1: sticky, set on any dropped entry.
- `drop_cnt_o` output, 16: saturating dropped-entry count (see Configuration).
- `level_o` output, $clog2(DEPTH)+1: current occupancy `count`.

## Operation
- Storage: `DEPTH`×`fifo_entry_s` array, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrapping modulo `DEPTH`, and `count` of $clog2(DEPTH)+1 bits.
- `push_n` = `port0.valid` + `port1.valid` (0..2).
- Push ordering:
  - port0 is written at `wr_ptr`.
  - port1 is written at `wr_ptr+1` if port0 is valid, else at `wr_ptr`.
  - `wr_ptr += push_n`.
- Accept rule:
  - Pushes are accepted only when `ready_o` = (`DEPTH` − `count` ≥ 2).
  - If `ready_o`=0 and `push_n`>0, both entries that cycle are dropped as a unit; no partial push.
  - A drop sets `overflow_o` and adds `push_n` to the drop counter.
- Pop:
  - Every cycle with `count`>0, the head `mem[rd_ptr]` is loaded into `fifo_entry_o` with `.valid` forced to 1, and `rd_ptr` increments.
  - With `count`=0, `fifo_entry_o` is cleared to all zeros (`.valid`=0).
  - There is no ready from downstream; the FSM accepts every cycle.
- Occupancy: `count_next` = `count` + accepted `push_n` − pop. Push and pop in the same cycle are always legal.
- Pop sees only `count` at the start of the cycle. Entries pushed this cycle are never popped this cycle.
- Flush (`flush_i`=1), at the next edge:
  - `count`, `wr_ptr` and `rd_ptr` are set to 0 and `fifo_entry_o` is cleared.
  - Pushes in the same cycle are discarded and are not counted as drops.
  - Flush has priority over push and pop.
- `overflow_o` and the drop counter clear only on reset.

## Timing
- Reset values while `rst_i` is high:
  - `fifo_entry_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `level_o`=0.
  - `ready_o`=1.
  - Pointers at 0.
- Reset is asynchronous: it takes effect immediately, including mid-stream; buffered entries are lost.
- Latency: an entry sampled at edge k is visible on `fifo_entry_o` after edge k+1, if it is at the head.
- Throughput: 1 entry/cycle out, 2 entries/cycle in.
  - Sustained dual-commit fills the FIFO.
  - `ready_o` falls when `count` ≥ `DEPTH`−1.
- Full/empty boundaries:
  - `count`=`DEPTH`−2 accepts a pair.
  - `count`=`DEPTH`−1 drops even a single push.
  - `count`=0 outputs invalid.
- `level_o` and `ready_o` reflect the registered `count`; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `INGRESS_SCHED_DROPCNT_EN`.
- Defined:
  - `drop_cnt_o` is a 16-bit counter incremented by the dropped `push_n`.
  - It saturates at 0xFFFF and resets to 0.
- Undefined:
  - No counter flops are generated and `drop_cnt_o` is tied to 0.
  - `overflow_o` behaves identically in both builds.

## Test plan
- Reset then idle: `rst_i` pulse, no pushes → `fifo_entry_o.valid`=0, `ready_o`=1, `level_o`=0 for 10 cycles.
- Ordered dual push: one cycle with port0 pc=0x100 and port1 pc=0x104 valid, then idle → output pc 0x100 then 0x104 on consecutive cycles, first valid two edges after the push; `level_o` goes 2, 1, 0.
- Port1-only push: port1 pc=0x200, port0 invalid → single output pc=0x200; no gap or hole entry.
- Fill and drop, `DEPTH`=8: dual pushes every cycle → `ready_o` deasserts once `count`≥7. The next dual push is dropped, `overflow_o`=1, and `drop_cnt_o`=2 with the macro defined (0 without it). Drained order equals accepted order with no loss.
- Wrap-around: 20 cycles of alternating single/dual pushes with continuous pop → the output sequence matches the push order across pointer wrap.
- Flush mid-stream: `level_o`=5, then `flush_i` asserted together with a dual push → next cycle `level_o`=0 and `fifo_entry_o.valid`=0; `drop_cnt_o` and `overflow_o` are unchanged.

Source files
------------

// File: rtl/ingress_port_sched.sv
// Two-port commit scheduler: buffers both CVA6 commit ports in program order and
// streams one fifo_entry_s per cycle to ingress_fsm. Optional drop counter: INGRESS_SCHED_DROPCNT_EN.

package mure_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] instr;
   } fifo_entry_s;
endpackage

module ingress_port_sched
   import mure_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  fifo_entry_s                port0_entry_i,
   input  fifo_entry_s                port1_entry_i,
   input  logic                       flush_i,
   output logic                       ready_o,
   output fifo_entry_s                fifo_entry_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fifo_entry_s   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic [1:0]    push_n;
   logic [1:0]    acc_n;
   logic          accept;
   logic          drop;
   logic          pop;
   logic          wr0_en;
   logic          wr1_en;
   logic [AW-1:0] wr1_addr;
   fifo_entry_s   head;

   // Pushes are all-or-nothing, and a flush discards them without counting a drop.
   always_comb begin
      push_n   = {1'b0, port0_entry_i.valid} + {1'b0, port1_entry_i.valid};
      ready_o  = (count <= CW'(DEPTH - 2));
      accept   = ready_o && (push_n != 2'd0) && !flush_i;
      drop     = !ready_o && (push_n != 2'd0) && !flush_i;
      acc_n    = accept ? push_n : 2'd0;
      pop      = (count != '0);
      wr0_en   = accept && port0_entry_i.valid;
      wr1_en   = accept && port1_entry_i.valid;
      wr1_addr = port0_entry_i.valid ? (wr_ptr + AW'(1)) : wr_ptr;
      head       = mem[rd_ptr];
      head.valid = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (wr0_en) mem[wr_ptr]   <= port0_entry_i;
      if (wr1_en) mem[wr1_addr] <= port1_entry_i;
   end

   // Pop only looks at the registered count, so this cycle's pushes are never bypassed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fifo_entry_o <= '0;
      end else if (flush_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fifo_entry_o <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(acc_n);
         count  <= count + CW'(acc_n) - CW'(pop);
         if (pop) begin
            rd_ptr       <= rd_ptr + AW'(1);
            fifo_entry_o <= head;
         end else begin
            fifo_entry_o <= '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     overflow_o <= 1'b0;
      else if (drop) overflow_o <= 1'b1;
   end

`ifdef INGRESS_SCHED_DROPCNT_EN
   logic [16:0] drop_sum;
   logic [15:0] drop_cnt;

   always_comb begin
      drop_sum = {1'b0, drop_cnt} + 17'(push_n);
   end

   // Saturates at all-ones rather than wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     drop_cnt <= '0;
      else if (drop) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   assign drop_cnt_o = drop_cnt;
`else
   assign drop_cnt_o = '0;
`endif

   assign level_o = count;

endmodule

// File: tb/tb_ingress_port_sched.sv
// Scoreboard bench for ingress_port_sched: a queue-based reference model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.

module tb_ingress_port_sched;
   import mure_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct {
      fifo_entry_s entry;
      int          level;
      bit          ready;
      bit          ovf;
      int          dcnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   fifo_entry_s   p0 = '0;
   logic          flush = 1'b0;
   fifo_entry_s   p1 = '0;
   logic          ready;
   fifo_entry_s   out;
   logic          ovf;
   logic [15:0]   dcnt;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;

   fifo_entry_s modelQ[$];
   bit          modelOvf = 0;
   int          modelDrops = 0;
   exp_t        sbQ[$];

   ingress_port_sched #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .port0_entry_i (p0),
      .port1_entry_i (p1),
      .flush_i       (flush),
      .ready_o       (ready),
      .fifo_entry_o  (out),
      .overflow_o    (ovf),
      .drop_cnt_o    (dcnt),
      .level_o       (level)
   );

   always #5 clk = ~clk;

   function automatic fifo_entry_s mkEntry(bit v, logic [63:0] pc);
      fifo_entry_s e;
      e.valid = v;
      e.pc    = pc;
      e.instr = $urandom;
      return e;
   endfunction

   task automatic checkField(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(exp_t e);
      int expDrops;
`ifdef INGRESS_SCHED_DROPCNT_EN
      expDrops = e.dcnt;
`else
      expDrops = 0;
`endif
      checkField("entry", 128'(out), 128'(e.entry));
      checkField("level", 128'(level), 128'(e.level));
      checkField("ready", 128'(ready), 128'(e.ready));
      checkField("overflow", 128'(ovf), 128'(e.ovf));
      checkField("drop_cnt", 128'(dcnt), 128'(expDrops));
   endtask

   // Drive one cycle of inputs; predict the post-edge outputs from the queue model.
   task automatic applyStimulus(fifo_entry_s e0, fifo_entry_s e1, bit fl);
      exp_t e;
      int   n;
      bit   rdy;
      p0    = e0;
      p1    = e1;
      flush = fl;
      n     = int'(e0.valid) + int'(e1.valid);
      rdy   = (DEPTH - modelQ.size()) >= 2;
      e.entry = '0;
      if (fl) begin
         modelQ.delete();
      end else begin
         if (modelQ.size() > 0) begin
            e.entry = modelQ.pop_front();
            e.entry.valid = 1'b1;
         end
         if (n > 0) begin
            if (rdy) begin
               if (e0.valid) modelQ.push_back(e0);
               if (e1.valid) modelQ.push_back(e1);
            end else begin
               modelOvf   = 1;
               modelDrops = (modelDrops + n > 65535) ? 65535 : modelDrops + n;
            end
         end
      end
      e.level = modelQ.size();
      e.ready = (DEPTH - modelQ.size()) >= 2;
      e.ovf   = modelOvf;
      e.dcnt  = modelDrops;
      @(posedge clk);
      #1;
      sbQ.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
   end

   task automatic resetModel();
      modelQ.delete();
      modelOvf   = 0;
      modelDrops = 0;
      sbQ.delete();
   endtask

   initial begin
      exp_t zero;
      fifo_entry_s idle;
      idle = '0;
      zero.entry = '0; zero.level = 0; zero.ready = 1; zero.ovf = 0; zero.dcnt = 0;

      #1;
      checkOutput(zero);
      @(posedge clk);
      #1;
      rst = 1'b0;

      repeat (10) applyStimulus(idle, idle, 0);

      applyStimulus(mkEntry(1, 64'h100), mkEntry(1, 64'h104), 0);
      repeat (4) applyStimulus(idle, idle, 0);

      applyStimulus(mkEntry(0, 64'hDEAD), mkEntry(1, 64'h200), 0);
      repeat (3) applyStimulus(idle, idle, 0);

      for (int i = 0; i < 12; i++)
         applyStimulus(mkEntry(1, 64'h1000 + 64'(8 * i)), mkEntry(1, 64'h1004 + 64'(8 * i)), 0);
      repeat (10) applyStimulus(idle, idle, 0);

      for (int i = 0; i < 20; i++)
         applyStimulus(mkEntry(1, 64'h2000 + 64'(8 * i)), mkEntry(i % 2 == 1, 64'h2004 + 64'(8 * i)), 0);
      repeat (10) applyStimulus(idle, idle, 0);

      for (int i = 0; i < 4; i++)
         applyStimulus(mkEntry(1, 64'h3000 + 64'(8 * i)), mkEntry(1, 64'h3004 + 64'(8 * i)), 0);
      applyStimulus(mkEntry(1, 64'h3100), mkEntry(1, 64'h3104), 1);
      repeat (3) applyStimulus(idle, idle, 0);

      for (int i = 0; i < 400; i++) begin
         int r0 = $urandom_range(0, 99);
         int r1 = $urandom_range(0, 99);
         applyStimulus(mkEntry(r0 < 70, {32'h0, $urandom}), mkEntry(r1 < 60, {32'h0, $urandom}),
                       $urandom_range(0, 99) < 3);
      end

      // Asynchronous reset mid-stream must clear state without waiting for an edge.
      for (int i = 0; i < 5; i++)
         applyStimulus(mkEntry(1, 64'h4000 + 64'(8 * i)), mkEntry(1, 64'h4004 + 64'(8 * i)), 0);
      sbQ.delete();
      p0 = '0;
      p1 = '0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput(zero);
      resetModel();
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(mkEntry(1, 64'h5000), mkEntry(1, 64'h5004), 0);
      repeat (4) applyStimulus(idle, idle, 0);

      @(posedge clk);
      #1;
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
